// File: rtl/boot_loader.sv
// Byte-stream boot loader: packs little-endian bytes into words and writes them to instruction memory.
// The core is held in reset until the image and its XOR checksum verify. BOOT_LOADER_TIMEOUT_EN adds an idle-stream timeout.
module boot_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ADDR_WIDTH    = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  req_valid,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  valid_data,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_COUNT = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("boot_loader: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("boot_loader: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]            state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [BIDX_W-1:0]     bidx_q, bidx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            csum_q, csum_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            code_q, code_d;

    logic                  accept;
    logic                  last_byte;
    logic                  last_word;
    logic                  count_bad;
    logic [DATA_WIDTH-1:0] assembled;

    assign in_ready  = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign accept    = in_valid && in_ready;
    assign last_byte = (32'(bidx_q) == 32'(BYTES - 1));
    assign last_word = (32'(widx_q) == (32'(count_q) - 32'd1));
    assign count_bad = (in_data == 8'd0) || (32'(in_data) > 32'(MEM_DEPTH));
    // Shift in from the top so the first byte of a word ends up in bits [7:0].
    assign assembled = (word_q >> 8) | (DATA_WIDTH'(in_data) << (DATA_WIDTH - 8));

`ifdef BOOT_LOADER_TIMEOUT_EN
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    localparam int         TMR_W       = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timed_out;

    assign timed_out = in_ready && !accept && ((32'(tmr_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        csum_d  = csum_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        code_d  = code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    count_d = in_data;
                    if (count_bad) begin
                        state_d = S_ERR;
                        code_d  = ERR_COUNT;
                    end else begin
                        state_d = S_LOAD;
                        widx_d  = '0;
                        bidx_d  = '0;
                        csum_d  = '0;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    word_d = assembled;
                    csum_d = csum_q ^ in_data;
                    if (last_byte) begin
                        bidx_d  = '0;
                        state_d = S_WRITE;
                        req_d   = 1'b1;
                        addr_d  = widx_q;
                        data_d  = assembled;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                if (req_q && valid_data) begin
                    req_d = 1'b0;
                    if (last_word) begin
                        state_d = S_CSUM;
                    end else begin
                        widx_d  = widx_q + ADDR_WIDTH'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_CSUM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                    code_d  = ERR_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BOOT_LOADER_TIMEOUT_EN
        if (timed_out) begin
            state_d = S_ERR;
            code_d  = ERR_TIMEOUT;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            code_q  <= code_d;
        end
    end

`ifdef BOOT_LOADER_TIMEOUT_EN
    // Idle counter restarts on every accepted byte and on every state change.
    always_comb begin
        tmr_d = tmr_q + TMR_W'(1);
        if ((state_d != state_q) || accept || !in_ready) begin
            tmr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`endif

    assign req_valid  = req_q;
    assign we         = req_q;
    assign addr       = addr_q;
    assign data       = data_q;
    assign core_hold  = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);
    assign error_code = code_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: nominal load, bad count, checksum error, backpressure, mid-load reset, timeout.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [5:0]  addr;
    logic        req_valid;
    logic        we;
    logic [31:0] data;
    logic        valid_data = 1'b0;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    int n_vec  = 0;
    int n_miss = 0;

    int          ack_delay = 0;
    logic        spurious  = 1'b0;
    int          hold_cnt  = 0;
    logic [5:0]  held_addr;
    logic [31:0] held_data;
    logic [5:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_run[$];
    logic [7:0]  img[$];

    boot_loader #(
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .addr      (addr),
        .req_valid (req_valid),
        .we        (we),
        .data      (data),
        .valid_data(valid_data),
        .core_hold (core_hold),
        .done      (done),
        .error     (error),
        .error_code(error_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: acks after ack_delay wait cycles, logs each write, checks request stability.
    always @(negedge clk) begin
        if (req_valid === 1'b1) begin
            check_eq("we_with_req", {31'd0, we}, 32'd1);
            check_eq("in_ready_in_write", {31'd0, in_ready}, 32'd0);
            if (hold_cnt == 0) begin
                held_addr = addr;
                held_data = data;
            end else begin
                check_eq("addr_stable", {26'd0, addr}, {26'd0, held_addr});
                check_eq("data_stable", data, held_data);
            end
            hold_cnt++;
            if (hold_cnt > ack_delay) begin
                valid_data = 1'b1;
                wr_addr.push_back(addr);
                wr_data.push_back(data);
                wr_run.push_back(hold_cnt);
                hold_cnt = 0;
            end else begin
                valid_data = 1'b0;
            end
        end else begin
            valid_data = spurious;
            hold_cnt   = 0;
        end
    end

    task automatic check_reset_vals(input string tg);
        check_eq({tg, "_in_ready"},   {31'd0, in_ready},   32'd0);
        check_eq({tg, "_req_valid"},  {31'd0, req_valid},  32'd0);
        check_eq({tg, "_we"},         {31'd0, we},         32'd0);
        check_eq({tg, "_addr"},       {26'd0, addr},       32'd0);
        check_eq({tg, "_data"},       data,                32'd0);
        check_eq({tg, "_core_hold"},  {31'd0, core_hold},  32'd1);
        check_eq({tg, "_done"},       {31'd0, done},       32'd0);
        check_eq({tg, "_error"},      {31'd0, error},      32'd0);
        check_eq({tg, "_error_code"}, {30'd0, error_code}, 32'd0);
    endtask

    task automatic reset_dut();
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        wr_run.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents a byte and holds it until the DUT accepts it; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_image(input int count);
        for (int i = 0; i < count; i++) send_byte(img[i]);
    endtask

    task automatic check_nominal_writes(input string tg);
        check_eq({tg, "_nwr"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check_eq({tg, "_addr0"}, {26'd0, wr_addr[0]}, 32'd0);
            check_eq({tg, "_data0"}, wr_data[0], 32'h0000_0013);
            check_eq({tg, "_addr1"}, {26'd0, wr_addr[1]}, 32'd1);
            check_eq({tg, "_data1"}, wr_data[1], 32'h0010_0093);
        end
    endtask

    initial begin
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        reset_dut();
        check_reset_vals("rst");

        // Nominal load
        img = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        pulse_start();
        check_eq("nom_hdr_ready", {31'd0, in_ready}, 32'd1);
        send_image(10);
        check_nominal_writes("nom");
        check_eq("nom_done", {31'd0, done}, 32'd1);
        check_eq("nom_core_hold", {31'd0, core_hold}, 32'd0);
        check_eq("nom_error", {31'd0, error}, 32'd0);
        check_eq("nom_code", {30'd0, error_code}, 32'd0);
        check_eq("nom_in_ready", {31'd0, in_ready}, 32'd0);
        pulse_start();
        @(negedge clk);
        check_eq("done_sticky", {31'd0, done}, 32'd1);
        check_eq("done_no_hdr", {31'd0, in_ready}, 32'd0);

        // Bad word counts, then recovery
        reset_dut();
        pulse_start();
        send_byte(8'h00);
        check_eq("cnt0_error", {31'd0, error}, 32'd1);
        check_eq("cnt0_code", {30'd0, error_code}, 32'd1);
        check_eq("cnt0_core_hold", {31'd0, core_hold}, 32'd1);
        check_eq("cnt0_nwr", wr_addr.size(), 32'd0);
        pulse_start();
        check_eq("err_start_error", {31'd0, error}, 32'd0);
        check_eq("err_start_code", {30'd0, error_code}, 32'd0);
        send_byte(8'h41);
        check_eq("cnt65_error", {31'd0, error}, 32'd1);
        check_eq("cnt65_code", {30'd0, error_code}, 32'd1);
        check_eq("cnt65_nwr", wr_addr.size(), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("err_code_held", {30'd0, error_code}, 32'd1);
        pulse_start();
        send_image(10);
        check_nominal_writes("recov");
        check_eq("recov_done", {31'd0, done}, 32'd1);

        // Checksum mismatch
        reset_dut();
        img[9] = 8'h91;
        pulse_start();
        send_image(10);
        check_nominal_writes("csum");
        check_eq("csum_error", {31'd0, error}, 32'd1);
        check_eq("csum_code", {30'd0, error_code}, 32'd2);
        check_eq("csum_core_hold", {31'd0, core_hold}, 32'd1);
        check_eq("csum_done", {31'd0, done}, 32'd0);
        img[9] = 8'h90;

        // Memory backpressure with stray valid_data outside WRITE
        reset_dut();
        ack_delay = 3;
        spurious  = 1'b1;
        pulse_start();
        send_image(10);
        check_nominal_writes("bp");
        for (int i = 0; i < wr_run.size(); i++) check_eq("bp_req_cycles", wr_run[i], 32'd4);
        check_eq("bp_done", {31'd0, done}, 32'd1);
        ack_delay = 0;
        spurious  = 1'b0;

        // Reset after byte 3 of word 1
        reset_dut();
        pulse_start();
        send_image(8);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        reset_dut();
        pulse_start();
        send_image(10);
        check_nominal_writes("reload");
        check_eq("reload_done", {31'd0, done}, 32'd1);

        // Idle stream after count byte 01
        reset_dut();
        pulse_start();
        send_byte(8'h01);
        repeat (15) @(posedge clk);
        #1;
        check_eq("tmo_pre_error", {31'd0, error}, 32'd0);
        check_eq("tmo_pre_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
`ifdef BOOT_LOADER_TIMEOUT_EN
        check_eq("tmo_error", {31'd0, error}, 32'd1);
        check_eq("tmo_code", {30'd0, error_code}, 32'd3);
        check_eq("tmo_core_hold", {31'd0, core_hold}, 32'd1);
`else
        repeat (40) @(posedge clk);
        #1;
        check_eq("wait_error", {31'd0, error}, 32'd0);
        check_eq("wait_ready", {31'd0, in_ready}, 32'd1);
        check_eq("wait_core_hold", {31'd0, core_hold}, 32'd1);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h13);
        check_eq("wait_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) check_eq("wait_data0", wr_data[0], 32'h0000_0013);
        check_eq("wait_done", {31'd0, done}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Upstream of the SOC core/memory pair: receives a program image as a byte stream, packs the bytes into DATA_WIDTH words, and writes them into instruction memory over the SOC memory request interface.
- Holds the core in reset until the whole image is written and its checksum passes.
- Replaces hard-coded memory init in bring-up benches and on the FPGA.

Parameters:
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- MEM_DEPTH, 64, number of words in the target memory.
- ADDR_WIDTH, $clog2(MEM_DEPTH), derived localparam; not overridable.
- TIMEOUT_CYCLES, 1024, idle-stream limit; used only with BOOT_LOADER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load from IDLE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- addr  out  ADDR_WIDTH  memory word address.
- req_valid  out  1  memory request valid.
- we  out  1  write enable; 1 whenever req_valid = 1.
- data  out  DATA_WIDTH  write data.
- valid_data  in  1  memory write acknowledge.
- core_hold  out  1  1 = core held in reset.
- done  out  1  image loaded and verified.
- error  out  1  load failed.
- error_code  out  2  0 none, 1 bad word count, 2 checksum mismatch, 3 timeout.

Behaviour:
- Reset values: state = IDLE; in_ready = 0, req_valid = 0, we = 0, addr = 0, data = 0; core_hold = 1; done = 0, error = 0, error_code = 0.
- Reset is asynchronous and wins over everything: a mid-load reset aborts immediately and discards the partial word, byte index, word counter and checksum.
- Stream format:
  - 1 byte word count N; valid range 1..MEM_DEPTH.
  - N words, each DATA_WIDTH/8 bytes, little-endian (first byte -> bits [7:0]).
  - 1 checksum byte = XOR of all data bytes. The count byte is excluded.
- IDLE: in_ready = 0. start -> HDR.
- HDR: in_ready = 1.
  - On accept, N is latched.
  - N == 0 or N > MEM_DEPTH -> ERR, code 1.
  - Otherwise -> LOAD; word index, byte index and checksum are cleared.
- LOAD: in_ready = 1.
  - Each accepted byte is shifted into the word register and XORed into the checksum.
  - The last byte of a word -> WRITE on the next cycle.
- WRITE: in_ready = 0; req_valid = 1, we = 1, addr = word index, data = assembled word. All four are registered and held stable until valid_data is sampled high.
  - valid_data is sampled only while req_valid = 1; valid_data in any other state is ignored.
  - The ack cycle drops req_valid and we on the next edge, then:
    - word index == N-1 -> CSUM.
    - otherwise word index += 1 -> LOAD.
  - Minimum cost is 1 cycle per word beyond byte accept, when valid_data returns in the same cycle.
- CSUM: in_ready = 1. On accept:
  - byte == running XOR -> DONE.
  - mismatch -> ERR, code 2. Words already written remain in memory.
- DONE: in_ready = 0; done = 1; core_hold = 0 from the cycle DONE is entered. DONE is terminal until reset; start is ignored.
- ERR: in_ready = 0; error = 1; core_hold = 1; error_code holds its value.
  - start -> HDR; error and error_code clear on that transition.
- start is ignored in HDR, LOAD, WRITE and CSUM.
- in_valid while in_ready = 0: no byte is consumed; the source must hold the byte.
- Only one memory request is outstanding at any time. addr never exceeds N-1.

Optional Feature:
- Macro: BOOT_LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs in HDR, LOAD and CSUM and clears on every accepted byte and on each state entry.
  - Reaching TIMEOUT_CYCLES consecutive cycles without an accepted byte -> ERR, code 3.
  - WRITE is not timed.
- Not defined: no counter logic is built; error_code 3 is never produced and the loader waits indefinitely.

Test Plan:
- Nominal load: start; bytes 02, 13 00 00 00, 93 00 10 00, 90 -> writes addr0 = 0x00000013, then addr1 = 0x00100093; done = 1, core_hold = 0, error = 0.
- Bad count: count byte 00 -> ERR, code 1, no req_valid. Count byte 41 (65 > 64) -> ERR, code 1. Then start plus a valid image -> done.
- Checksum mismatch: same image as nominal with checksum 91 -> both words written, then error = 1, code 2, core_hold stays 1.
- Memory backpressure: valid_data delayed 3 cycles on each write:
  - req_valid, addr and data stay stable for 4 cycles.
  - in_ready = 0 throughout; in_valid held by the source is not consumed.
  - Final state is done.
- Reset mid-load: assert reset after byte 3 of word 1 -> all outputs at reset values immediately. Then start plus the full image -> correct load from addr 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): count 01 then silence for 16 cycles -> ERR, code 3. Without the macro, the same stimulus leaves the loader waiting in LOAD.
